// File: rtl/axi_slave_ram.sv
// Word-addressed RAM behind an AXI-style slave port.
// The write engine (AW/W/B) and the read engine (AR/R) run independently; all outputs are registered.
module axi_slave_ram #(
   parameter int unsigned ID_WIDTH   = 2,
   parameter logic [31:0] ADDR_BASE  = 32'h0000_0000,
   parameter int unsigned DEPTH_LOG2 = 8
) (
   input  logic                SLAVE_CLK,
   input  logic                SLAVE_RSTN,
   input  logic [ID_WIDTH-1:0] SLAVE_WR_ADDR_ID,
   input  logic [31:0]         SLAVE_WR_ADDR,
   input  logic [7:0]          SLAVE_WR_ADDR_LEN,
   input  logic [1:0]          SLAVE_WR_ADDR_BURST,
   input  logic                SLAVE_WR_ADDR_VALID,
   output logic                SLAVE_WR_ADDR_READY,
   input  logic [31:0]         SLAVE_WR_DATA,
   input  logic [3:0]          SLAVE_WR_STRB,
   input  logic                SLAVE_WR_DATA_LAST,
   input  logic                SLAVE_WR_DATA_VALID,
   output logic                SLAVE_WR_DATA_READY,
   output logic [ID_WIDTH-1:0] SLAVE_WR_BACK_ID,
   output logic [1:0]          SLAVE_WR_BACK_RESP,
   output logic                SLAVE_WR_BACK_VALID,
   input  logic                SLAVE_WR_BACK_READY,
   input  logic [ID_WIDTH-1:0] SLAVE_RD_ADDR_ID,
   input  logic [31:0]         SLAVE_RD_ADDR,
   input  logic [7:0]          SLAVE_RD_ADDR_LEN,
   input  logic [1:0]          SLAVE_RD_ADDR_BURST,
   input  logic                SLAVE_RD_ADDR_VALID,
   output logic                SLAVE_RD_ADDR_READY,
   output logic [ID_WIDTH-1:0] SLAVE_RD_BACK_ID,
   output logic [31:0]         SLAVE_RD_DATA,
   output logic [1:0]          SLAVE_RD_DATA_RESP,
   output logic                SLAVE_RD_DATA_LAST,
   output logic                SLAVE_RD_DATA_VALID,
   input  logic                SLAVE_RD_DATA_READY
);

   localparam int unsigned DEPTH       = 1 << DEPTH_LOG2;
   localparam logic [1:0]  BURST_FIXED = 2'b00;
   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;
   localparam logic [1:0]  RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

   logic [31:0] mem [DEPTH];

   // Window test and word index both work on the offset from the base; addr[1:0] drop out.
   function automatic logic in_window(input logic [31:0] a);
      return ((a - ADDR_BASE) >> (DEPTH_LOG2 + 2)) == 32'd0;
   endfunction

   function automatic logic [DEPTH_LOG2-1:0] word_index(input logic [31:0] a);
      return DEPTH_LOG2'((a - ADDR_BASE) >> 2);
   endfunction

   // ---------------- write engine ----------------
   w_state_t              w_state, w_state_n;
   logic [ID_WIDTH-1:0]   w_id, w_id_n;
   logic [31:0]           w_addr, w_addr_n;
   logic [7:0]            w_len, w_len_n;
   logic [1:0]            w_burst, w_burst_n;
   logic [7:0]            w_beat, w_beat_n;
   logic                  w_dec, w_dec_n;
   logic                  w_slv, w_slv_n;
   logic                  aw_ready, aw_ready_n;
   logic                  w_ready, w_ready_n;
   logic                  b_valid, b_valid_n;
   logic [ID_WIDTH-1:0]   b_id, b_id_n;
   logic [1:0]            b_resp, b_resp_n;
   logic                  mem_we_c;

   always_comb begin
      w_state_n = w_state;
      w_id_n    = w_id;
      w_addr_n  = w_addr;
      w_len_n   = w_len;
      w_burst_n = w_burst;
      w_beat_n  = w_beat;
      w_dec_n   = w_dec;
      w_slv_n   = w_slv;
      mem_we_c  = 1'b0;
      case (w_state)
         W_IDLE: begin
            if (SLAVE_WR_ADDR_VALID && aw_ready) begin
               w_id_n    = SLAVE_WR_ADDR_ID;
               w_addr_n  = SLAVE_WR_ADDR;
               w_len_n   = SLAVE_WR_ADDR_LEN;
               w_burst_n = SLAVE_WR_ADDR_BURST;
               w_beat_n  = 8'd0;
               w_dec_n   = 1'b0;
               w_slv_n   = 1'b0;
               w_state_n = W_DATA;
            end
         end
         W_DATA: begin
            if (SLAVE_WR_DATA_VALID && w_ready) begin
               mem_we_c = in_window(w_addr);
               if (!in_window(w_addr)) w_dec_n = 1'b1;
               // LAST must coincide exactly with beat LEN; the beat count alone ends the burst.
               if (SLAVE_WR_DATA_LAST != (w_beat == w_len)) w_slv_n = 1'b1;
               if (w_burst != BURST_FIXED) w_addr_n = w_addr + 32'd4;
               w_beat_n = w_beat + 8'd1;
               if (w_beat == w_len) w_state_n = W_RESP;
            end
         end
         W_RESP: begin
            if (SLAVE_WR_BACK_READY && b_valid) w_state_n = W_IDLE;
         end
         default: w_state_n = W_IDLE;
      endcase
      aw_ready_n = (w_state_n == W_IDLE);
      w_ready_n  = (w_state_n == W_DATA);
      b_valid_n  = (w_state_n == W_RESP);
      b_id_n     = b_valid_n ? w_id_n : '0;
      if (!b_valid_n)   b_resp_n = RESP_OKAY;
      else if (w_dec_n) b_resp_n = RESP_DECERR;
      else if (w_slv_n) b_resp_n = RESP_SLVERR;
      else              b_resp_n = RESP_OKAY;
   end

   always_ff @(posedge SLAVE_CLK or negedge SLAVE_RSTN) begin
      if (!SLAVE_RSTN) begin
         w_state  <= W_IDLE;
         w_id     <= '0;
         w_addr   <= 32'd0;
         w_len    <= 8'd0;
         w_burst  <= 2'b00;
         w_beat   <= 8'd0;
         w_dec    <= 1'b0;
         w_slv    <= 1'b0;
         aw_ready <= 1'b0;
         w_ready  <= 1'b0;
         b_valid  <= 1'b0;
         b_id     <= '0;
         b_resp   <= 2'b00;
      end else begin
         w_state  <= w_state_n;
         w_id     <= w_id_n;
         w_addr   <= w_addr_n;
         w_len    <= w_len_n;
         w_burst  <= w_burst_n;
         w_beat   <= w_beat_n;
         w_dec    <= w_dec_n;
         w_slv    <= w_slv_n;
         aw_ready <= aw_ready_n;
         w_ready  <= w_ready_n;
         b_valid  <= b_valid_n;
         b_id     <= b_id_n;
         b_resp   <= b_resp_n;
      end
   end

   // Byte-lane RAM write; contents are deliberately not reset.
   always_ff @(posedge SLAVE_CLK) begin
      if (mem_we_c) begin
         for (int i = 0; i < 4; i++) begin
            if (SLAVE_WR_STRB[i]) mem[word_index(w_addr)][8*i +: 8] <= SLAVE_WR_DATA[8*i +: 8];
         end
      end
   end

   // ---------------- read engine ----------------
   r_state_t              r_state, r_state_n;
   logic [ID_WIDTH-1:0]   r_id, r_id_n;
   logic [31:0]           r_addr, r_addr_n;
   logic [7:0]            r_len, r_len_n;
   logic [1:0]            r_burst, r_burst_n;
   logic [7:0]            r_beat, r_beat_n;
   logic                  ar_ready, ar_ready_n;
   logic                  r_valid, r_valid_n;
   logic [31:0]           r_data, r_data_n;
   logic [1:0]            r_resp, r_resp_n;
   logic                  r_last, r_last_n;
   logic                  r_load_c;
   logic [31:0]           r_word_c;

   always_comb begin
      r_state_n = r_state;
      r_id_n    = r_id;
      r_addr_n  = r_addr;
      r_len_n   = r_len;
      r_burst_n = r_burst;
      r_beat_n  = r_beat;
      r_data_n  = r_data;
      r_resp_n  = r_resp;
      r_last_n  = r_last;
      r_load_c  = 1'b0;
      case (r_state)
         R_IDLE: begin
            if (SLAVE_RD_ADDR_VALID && ar_ready) begin
               r_id_n    = SLAVE_RD_ADDR_ID;
               r_addr_n  = SLAVE_RD_ADDR;
               r_len_n   = SLAVE_RD_ADDR_LEN;
               r_burst_n = SLAVE_RD_ADDR_BURST;
               r_beat_n  = 8'd0;
               r_load_c  = 1'b1;
               r_state_n = R_DATA;
            end
         end
         R_DATA: begin
            if (SLAVE_RD_DATA_READY && r_valid) begin
               if (r_beat == r_len) begin
                  r_state_n = R_IDLE;
               end else begin
                  r_beat_n = r_beat + 8'd1;
                  if (r_burst != BURST_FIXED) r_addr_n = r_addr + 32'd4;
                  r_load_c = 1'b1;
               end
            end
         end
         default: r_state_n = R_IDLE;
      endcase
      // Array read happens before this edge's write lands, so same-word collisions see old data.
      r_word_c = mem[word_index(r_addr_n)];
      if (r_load_c) begin
         r_data_n = in_window(r_addr_n) ? r_word_c : 32'd0;
         r_resp_n = in_window(r_addr_n) ? RESP_OKAY : RESP_DECERR;
         r_last_n = (r_beat_n == r_len_n);
      end else if (r_state_n == R_IDLE) begin
         r_id_n   = '0;
         r_data_n = 32'd0;
         r_resp_n = RESP_OKAY;
         r_last_n = 1'b0;
      end
      ar_ready_n = (r_state_n == R_IDLE);
      r_valid_n  = (r_state_n == R_DATA);
   end

   always_ff @(posedge SLAVE_CLK or negedge SLAVE_RSTN) begin
      if (!SLAVE_RSTN) begin
         r_state  <= R_IDLE;
         r_id     <= '0;
         r_addr   <= 32'd0;
         r_len    <= 8'd0;
         r_burst  <= 2'b00;
         r_beat   <= 8'd0;
         ar_ready <= 1'b0;
         r_valid  <= 1'b0;
         r_data   <= 32'd0;
         r_resp   <= 2'b00;
         r_last   <= 1'b0;
      end else begin
         r_state  <= r_state_n;
         r_id     <= r_id_n;
         r_addr   <= r_addr_n;
         r_len    <= r_len_n;
         r_burst  <= r_burst_n;
         r_beat   <= r_beat_n;
         ar_ready <= ar_ready_n;
         r_valid  <= r_valid_n;
         r_data   <= r_data_n;
         r_resp   <= r_resp_n;
         r_last   <= r_last_n;
      end
   end

   assign SLAVE_WR_ADDR_READY = aw_ready;
   assign SLAVE_WR_DATA_READY = w_ready;
   assign SLAVE_WR_BACK_VALID = b_valid;
   assign SLAVE_WR_BACK_ID    = b_id;
   assign SLAVE_WR_BACK_RESP  = b_resp;
   assign SLAVE_RD_ADDR_READY = ar_ready;
   assign SLAVE_RD_DATA_VALID = r_valid;
   assign SLAVE_RD_BACK_ID    = r_id;
   assign SLAVE_RD_DATA       = r_data;
   assign SLAVE_RD_DATA_RESP  = r_resp;
   assign SLAVE_RD_DATA_LAST  = r_last;

endmodule
